// File: rtl/franken_pkg.sv
// Shared definitions for the Franken data-port responder: MMIO map, STATUS layout,
// request payload and the TXDATA lane-select helper.
package franken_pkg;

   localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
   localparam logic [31:0] MMIO_TXDATA = 32'h8000_0000;
   localparam logic [31:0] MMIO_STATUS = 32'h8000_0004;
   localparam logic [31:0] MMIO_TIMER  = 32'h8000_0008;

   localparam int unsigned ST_FULL      = 0;
   localparam int unsigned ST_EMPTY     = 1;
   localparam int unsigned ST_OVF       = 2;
   localparam int unsigned ST_COUNT_LSB = 8;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned LANES   = 4;
   localparam int unsigned BYTE_W  = 8;

   typedef struct packed {
      logic [DATA_W-1:0] addr;
      logic              we;
      logic [LANES-1:0]  be;
      logic [DATA_W-1:0] wdata;
   } dmem_req_t;

   // Byte carried by a store: the lowest enabled lane wins.
   function automatic logic [BYTE_W-1:0] lane_byte(input logic [LANES-1:0] be,
                                                   input logic [DATA_W-1:0] wd);
      if (be[0])      return wd[7:0];
      else if (be[1]) return wd[15:8];
      else if (be[2]) return wd[23:16];
      else if (be[3]) return wd[31:24];
      else            return 8'd0;
   endfunction

endpackage

// File: rtl/franken_tx_fifo.sv
// Console transmit byte FIFO; head is shown whenever non-empty, zero otherwise.
// A push while full is accepted only if a pop happens in the same cycle.
module franken_tx_fifo #(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [7:0]                   push_data,
   input  logic                         pop,
   output logic [7:0]                   head_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(FIFO_DEPTH):0]  count,
   output logic                         drop
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign drop    = push && full && !do_pop;

   assign head_data = empty ? 8'd0 : mem[rd_ptr];

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push && !reset) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/franken_dmem_responder.sv
// Data-port responder for the Franken core: byte-writable RAM plus MMIO console
// FIFO, STATUS and cycle TIMER. Define FRANKEN_TIMER_EN to build the TIMER counter.
module franken_dmem_responder
   import franken_pkg::*;
#(
   parameter int unsigned MEM_WORDS  = 1024,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        mem_write,
   input  logic [3:0]  byte_enable,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   dmem_req_t          req;
   logic               wr_en;
   logic               sel_ram;
   logic               sel_tx;
   logic               sel_status;
   logic [AW-1:0]      ram_idx;
   logic [31:0]        ram [MEM_WORDS];
   logic [31:0]        status;
   logic               ovf;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CW-1:0]      fifo_count;
   logic               fifo_drop;
   logic               fifo_pop;
   logic               unused_addr_lsb;

   assign req = '{addr: addr, we: mem_write, be: byte_enable, wdata: write_data};
   assign unused_addr_lsb = ^req.addr[1:0];

   // Stores are squashed during reset, RAM included.
   assign wr_en      = req.we && !reset;
   assign sel_ram    = ((req.addr - RAM_BASE) >> (AW + 2)) == 32'd0;
   assign sel_tx     = (req.addr[31:2] == MMIO_TXDATA[31:2]);
   assign sel_status = (req.addr[31:2] == MMIO_STATUS[31:2]);
   assign ram_idx    = req.addr[AW+1:2];

   always_ff @(posedge clk) begin
      if (wr_en && sel_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (req.be[i]) ram[ram_idx][8*i +: 8] <= req.wdata[8*i +: 8];
         end
      end
   end

   assign fifo_pop = tx_valid && tx_ready;
   assign tx_valid = !fifo_empty;

   franken_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_en && sel_tx),
      .push_data (lane_byte(req.be, req.wdata)),
      .pop       (fifo_pop),
      .head_data (tx_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .drop      (fifo_drop)
   );

   // Sticky overflow; a dropped push outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (fifo_drop) begin
         ovf <= 1'b1;
      end else if (wr_en && sel_status && req.be[0] && req.wdata[ST_OVF]) begin
         ovf <= 1'b0;
      end
   end

   always_comb begin
      status                     = '0;
      status[ST_FULL]            = fifo_full;
      status[ST_EMPTY]           = fifo_empty;
      status[ST_OVF]             = ovf;
      status[ST_COUNT_LSB +: 8]  = 8'(fifo_count);
   end

`ifdef FRANKEN_TIMER_EN
   logic        sel_timer;
   logic [31:0] timer_q;
   logic [31:0] timer_inc;
   logic [31:0] timer_d;

   assign sel_timer = (req.addr[31:2] == MMIO_TIMER[31:2]);
   assign timer_inc = timer_q + 32'd1;

   // Written lanes load store data, untouched lanes keep counting.
   always_comb begin
      timer_d = timer_inc;
      if (wr_en && sel_timer) begin
         for (int i = 0; i < 4; i++) begin
            if (req.be[i]) timer_d[8*i +: 8] = req.wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) timer_q <= '0;
      else       timer_q <= timer_d;
   end
`endif

   // Read mux is side-effect free; TXDATA and unmapped space read as zero.
   always_comb begin
      read_data = '0;
      if (sel_ram) begin
         read_data = ram[ram_idx];
      end else if (sel_status) begin
         read_data = status;
`ifdef FRANKEN_TIMER_EN
      end else if (sel_timer) begin
         read_data = timer_q;
`endif
      end
   end

endmodule

// File: tb/tb_franken_dmem_responder.sv
// Scoreboard bench for franken_dmem_responder: read expectations and TX bytes are
// queued at stimulus time and retired when the DUT produces them.
module tb_franken_dmem_responder;

   localparam logic [31:0] A_TX  = 32'h8000_0000;
   localparam logic [31:0] A_ST  = 32'h8000_0004;
   localparam logic [31:0] A_TMR = 32'h8000_0008;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        mem_write;
   logic [3:0]  byte_enable;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [31:0] rd_q [$];
   logic [7:0]  tx_q [$];

   franken_dmem_responder #(.MEM_WORDS(1024), .FIFO_DEPTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .addr        (addr),
      .mem_write   (mem_write),
      .byte_enable (byte_enable),
      .write_data  (write_data),
      .read_data   (read_data),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      addr = a; mem_write = 1'b1; byte_enable = be; write_data = d;
      tick();
      mem_write = 1'b0; byte_enable = 4'd0;
   endtask

   task automatic push_byte(input logic [3:0] be, input logic [31:0] d, input logic [7:0] exp);
      tx_q.push_back(exp);
      store(A_TX, be, d);
   endtask

   task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] want;
      rd_q.push_back(exp);
      addr = a;
      #1;
      want = rd_q.pop_front();
      check(tag, read_data, want);
   endtask

   task automatic drain(input string tag);
      tx_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (!tx_valid) break;
         tick();
      end
      tx_ready = 1'b0;
      check(tag, 32'(tx_valid), 32'd0);
      check({tag, "_sb_left"}, 32'(tx_q.size()), 32'd0);
   endtask

   // Retire expected console bytes on each handshake.
   always @(negedge clk) begin
      if (!reset && tx_valid && tx_ready) begin
         if (tx_q.size() == 0) check("tx_spurious", 32'(tx_q.size()), 32'd1);
         else check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] tmr_exp;
      reset = 1'b1; addr = '0; mem_write = 1'b0; byte_enable = '0;
      write_data = '0; tx_ready = 1'b0;

      // Reset state at the first reset edge
      tick();
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      reset = 1'b0;
      read_chk("rst_status", A_ST, 32'h0000_0002);

      // Timer: counts from the reset edge, then load and wrap
      read_chk("tmr_0", A_TMR, 32'd0);
      repeat (5) tick();
`ifdef FRANKEN_TIMER_EN
      tmr_exp = 32'd5;
`else
      tmr_exp = 32'd0;
`endif
      read_chk("tmr_n", A_TMR, tmr_exp);
      store(A_TMR, 4'b1111, 32'hFFFF_FFFE);
`ifdef FRANKEN_TIMER_EN
      tmr_exp = 32'hFFFF_FFFE;
`endif
      read_chk("tmr_ld", A_TMR, tmr_exp);
      tick();
`ifdef FRANKEN_TIMER_EN
      tmr_exp = 32'hFFFF_FFFF;
`endif
      read_chk("tmr_ld1", A_TMR, tmr_exp);
      tick();
`ifdef FRANKEN_TIMER_EN
      tmr_exp = 32'h0;
`endif
      read_chk("tmr_wrap", A_TMR, tmr_exp);

      // RAM byte lanes and read-during-write
      store(32'h10, 4'b1111, 32'hCAFE_F00D);
      addr = 32'h10; mem_write = 1'b1; byte_enable = 4'b1111; write_data = 32'h1122_3344;
      #1;
      check("ram_rdw_old", read_data, 32'hCAFE_F00D);
      tick();
      mem_write = 1'b0; byte_enable = 4'd0;
      read_chk("ram_sw", 32'h10, 32'h1122_3344);
      store(32'h12, 4'b0100, 32'h00AA_0000);
      read_chk("ram_sb", 32'h10, 32'h11AA_3344);
      store(32'h20, 4'b1111, 32'h55AA_55AA);
      read_chk("ram_w20", 32'h20, 32'h55AA_55AA);

      // TX stream
      push_byte(4'b0001, 32'h0000_0048, 8'h48);
      check("tx_latency", 32'(tx_valid), 32'd1);
      push_byte(4'b0010, 32'h0000_6900, 8'h69);
      read_chk("tx_status2", A_ST, 32'h0000_0200);
      check("tx_hold", 32'(tx_data), 32'h48);
      drain("tx_drain");
      read_chk("tx_status_e", A_ST, 32'h0000_0002);

      // Overflow, clear, then push+pop while full
      for (int i = 0; i < 8; i++) begin
         push_byte(4'b0001 << (i % 4), 32'(8'(8'h30 + i)) << (8 * (i % 4)), 8'(8'h30 + i));
      end
      store(A_TX, 4'b1111, 32'hDEAD_BE99);
      read_chk("ovf_status", A_ST, 32'h0000_0805);
      store(A_ST, 4'b0001, 32'h0000_0004);
      read_chk("ovf_clear", A_ST, 32'h0000_0801);
      tx_ready = 1'b1;
      push_byte(4'b1111, 32'h1234_5677, 8'h77);
      tx_ready = 1'b0;
      read_chk("full_pushpop", A_ST, 32'h0000_0801);
      drain("ovf_drain");

      // Reset mid-operation with a store in the reset cycle
      for (int i = 0; i < 3; i++) begin
         store(A_TX, 4'b0001, 32'(8'h41 + i));
      end
      check("pre_rst_valid", 32'(tx_valid), 32'd1);
      reset = 1'b1;
      addr = 32'h20; mem_write = 1'b1; byte_enable = 4'b1111; write_data = 32'hBAD0_BAD0;
      tick();
      reset = 1'b0; mem_write = 1'b0; byte_enable = 4'd0;
      check("midrst_valid", 32'(tx_valid), 32'd0);
      read_chk("midrst_status", A_ST, 32'h0000_0002);
      read_chk("midrst_ram", 32'h20, 32'h55AA_55AA);

      // Unmapped space
      store(32'h4000_0010, 4'b1111, 32'h1234_5678);
      read_chk("unmap_rd", 32'h4000_0010, 32'h0);
      read_chk("unmap_noalias", 32'h10, 32'h11AA_3344);
      read_chk("unmap_8000000c", 32'h8000_000C, 32'h0);
      read_chk("txdata_rd", A_TX, 32'h0);
      read_chk("post_status", A_ST, 32'h0000_0002);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/franken_dmem_responder.md
# franken_dmem_responder

Memory-side responder for the single-cycle Franken core's data port. It takes the core's address, write strobe, byte enables and write data, and returns read data in the same cycle. It implements a byte-writable word RAM and a small memory-mapped I/O region. The MMIO region holds a console transmit FIFO drained over a valid/ready stream, a status register and a free-running cycle timer.

## Interface
Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 8, console TX FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- addr  input  32  byte address from core (core's alu_result).
- mem_write  input  1  store strobe; high for one cycle per store.
- byte_enable  input  4  lane enables; one-hot for byte accesses, 4'b1111 for word accesses.
- write_data  input  32  store data, already lane-aligned by core.
- read_data  output  32  combinational read data for addr.
- tx_valid  output  1  FIFO head byte available.
- tx_data  output  8  FIFO head byte.
- tx_ready  input  1  downstream consumer accepts the head byte when tx_valid & tx_ready.

## Operation
- Address map, decoded on addr[31:2]:
  - RAM at 0x0000_0000 up to 4*MEM_WORDS-1.
  - TXDATA at 0x8000_0000.
  - STATUS at 0x8000_0004.
  - TIMER at 0x8000_0008.
  - Everything else is unmapped.
- RAM:
  - Reads are asynchronous, word-indexed by addr[2+log2(MEM_WORDS)-1:2].
  - Writes occur at the rising edge when mem_write=1; only lanes with byte_enable[i]=1 are updated.
  - Contents are not cleared by reset.
- TXDATA writes push one byte.
  - The byte is taken from the lowest enabled lane: be=0001→[7:0], 0010→[15:8], 0100→[23:16], 1000→[31:24], 1111→[7:0].
  - TXDATA reads return 0.
- STATUS reads:
  - bit0 = full.
  - bit1 = empty.
  - bit2 = overflow (sticky).
  - bits[15:8] = occupancy count.
  - All other bits are 0.
- STATUS writes: a write with write_data[2]=1 and byte_enable[0]=1 clears overflow. All other bits ignore writes.
- FIFO:
  - The head is presented whenever the FIFO is non-empty; tx_valid = !empty.
  - A pop happens on tx_valid & tx_ready.
  - A push while full with no pop in the same cycle is dropped and sets overflow.
  - Push and pop in the same cycle when full: both take effect; count stays at FIFO_DEPTH; no overflow.
  - Push and pop in the same cycle when empty cannot occur, because tx_valid=0.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Unmapped accesses: reads return 0; writes are ignored.
- Reads have no side effects. The core drives addresses on non-memory instructions, so reading any register never alters state.

## Timing
- read_data is combinational from addr in the same cycle.
  - A read of the address being written in that cycle returns the old value.
  - The new value is visible from the next cycle.
- TX push latency is 1 cycle. A push to an empty FIFO raises tx_valid in the cycle after the store.
- tx_data is stable while tx_valid=1 and tx_ready=0.
- TIMER:
  - Increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
  - On a TIMER write, the enabled lanes load write_data and the remaining lanes take the incremented value. The loaded value is read back next cycle, with no increment that cycle.
- Reset values at the first edge with reset=1:
  - FIFO empty, so tx_valid=0 and count=0.
  - tx_data=0.
  - overflow=0.
  - TIMER=0.
- Reset mid-operation discards FIFO contents. Stores in a reset cycle are ignored, including RAM.

## Configuration
- FRANKEN_TIMER_EN defined: TIMER counter is present as specified.
- FRANKEN_TIMER_EN undefined: no counter flops; reads of 0x8000_0008 return 0; writes are ignored.

## Structure
- Shared package franken_pkg holds:
  - Address constants: RAM_BASE, MMIO_TXDATA, MMIO_STATUS, MMIO_TIMER.
  - STATUS bit indices: ST_FULL, ST_EMPTY, ST_OVF, ST_COUNT_LSB.
- Sub-module franken_tx_fifo:
  - Parameterised FIFO_DEPTH.
  - push/pop/data interfaces; full, empty and count outputs.
  - Contains the simultaneous full push+pop rule.
- Top level holds the address decoder, RAM array, timer and read mux.

## Test plan
- RAM byte lanes: sw 0x1122_3344 at 0x10, then sb 0xAA at 0x12 → read 0x10 returns 0x11AA_3344. A read in the same cycle as the sw still returns the previous value.
- TX stream: sb 'H' (0x48) and 'i' (0x69) to 0x8000_0000 with tx_ready=0 → STATUS=0x0000_0200; with tx_ready=1, tx_data yields 0x48 then 0x69, then tx_valid=0 and STATUS=0x0000_0002.
- Overflow: with FIFO_DEPTH=8 and tx_ready=0, push 9 bytes → STATUS=0x0000_0805. A write of 0x4 to STATUS gives 0x0000_0801. A push concurrent with a pop while full gives no overflow and count 8.
- Timer: after reset, read TIMER N cycles later → N. Write 0xFFFF_FFFE → next reads are 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000. With FRANKEN_TIMER_EN undefined, reads are always 0.
- Reset mid-operation: 3 bytes queued, reset high for one cycle → tx_valid=0, STATUS=0x0000_0002, and a prior RAM word is unchanged.
- Unmapped: sw to 0x4000_0000 then read it → 0; no RAM word changes; read of TXDATA → 0.
